bus_word_serializer: RTL

//  Downstream stage of bus_control. Captures one BUS_SIZE-bit bus word plus its
//  per-word valid mask and emits the flagged WORD_SIZE-bit words one per cycle.

---
 rtl/bus_word_serializer.sv | 95 +++++++++
 1 files changed

// File: rtl/bus_word_serializer.sv
// Captures one bus word plus its per-word valid mask and streams the flagged
// words out most-significant first over a valid/ready handshake.
module bus_word_serializer #(
  parameter  int BUS_SIZE  = 16,
  parameter  int WORD_SIZE = 4,
  localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE,
  parameter  int IDX_W     = 2,
  parameter  int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_SIZE-1:0]  data_in,
  input  logic [WORD_NUM-1:0]  control_in,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] word_out,
  output logic [IDX_W-1:0]     word_idx,
  output logic                 word_last,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [CNT_W-1:0]     drop_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [BUS_SIZE-1:0] data_q, data_d;
  logic [WORD_NUM-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic [IDX_W-1:0]    hi_idx;
  logic                one_left;
  logic                offer;
  logic                transfer;
  logic                capture;

  // Ascending scan: the last set bit seen is the most significant pending word.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < WORD_NUM; i++) begin
      if (mask_q[i]) hi_idx = IDX_W'(i);
    end
  end

  assign one_left   = (mask_q != '0) && ((mask_q & (mask_q - WORD_NUM'(1))) == '0);
  assign word_valid = (state_q == SEND);
  assign word_out   = word_valid ? data_q[hi_idx*WORD_SIZE +: WORD_SIZE] : '0;
  assign word_idx   = word_valid ? hi_idx : '0;
  assign word_last  = word_valid & one_left;
  assign in_ready   = (state_q == IDLE) | (word_valid & word_last & word_ready);
  assign drop_count = drop_q;

  assign offer    = |control_in;
  assign transfer = word_valid & word_ready;
  assign capture  = offer & in_ready;

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    drop_d  = drop_q;

    if (transfer) begin
      mask_d[hi_idx] = 1'b0;
      if (word_last) state_d = IDLE;
    end

    // A capture on the final transfer edge overrides the return to IDLE.
    if (capture) begin
      data_d  = data_in;
      mask_d  = control_in;
      state_d = SEND;
    end else if (offer && drop_q != {CNT_W{1'b1}}) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together
  // from values sampled before the edge; the data register is reset too so the
  // idle outputs are fully defined.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      drop_q  <= drop_d;
    end
  end

endmodule
